// File: rtl/instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// instr_fetch_responder
//
// Instruction-memory responder for a core fetch port. A sequence driver
// pushes instruction words into an internal FIFO; every granted core fetch
// is answered with the FIFO head word, or with NOP_INSTR when the FIFO is
// empty. The response appears RESP_LATENCY cycles after the grant, with at
// most one fetch outstanding. For RESP_LATENCY=1 a fetch can be granted in
// the same cycle that the previous one is answered, giving one fetch per
// cycle.
//
// Parameters:
//   DEPTH        FIFO entries (power of two, >= 2)
//   RESP_LATENCY cycles from grant to rvalid (1..7)
//   NOP_INSTR    word returned when the FIFO is empty
//
// Ports:
//   clk              core clock
//   rst_i            synchronous reset, active-high
//   push_valid_i     driver offers push_instr_i
//   push_ready_o     FIFO not full (no pass-through when full)
//   push_instr_i     instruction word to queue
//   instr_req_i      core fetch request
//   instr_addr_i     core fetch address
//   instr_gnt_o      fetch granted (combinational from req and state)
//   instr_rvalid_o   response valid, one cycle per granted fetch
//   instr_rdata_o    response word, held while rvalid is low
//   level_o          FIFO occupancy
//   fetch_cnt_o      granted fetches (wraps at 2^32)
//   nop_cnt_o        NOP substitutions (wraps at 2^32)
//   last_addr_o      address of the most recent granted fetch
//
// Optional feature, macro FETCH_RESP_BRANCH_DETECT_EN:
//   branch_o         one-cycle pulse after a grant (other than the first one
//                    since reset) whose address is not last_addr_o + 4
//   branch_target_o  address of the most recent detected branch
// ---------------------------------------------------------------------------
module instr_fetch_responder #(
    parameter int          DEPTH        = 16,
    parameter int          RESP_LATENCY = 1,
    parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         rst_i,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [31:0]                  push_instr_i,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic [31:0]                  fetch_cnt_o,
    output logic [31:0]                  nop_cnt_o,
`ifdef FETCH_RESP_BRANCH_DETECT_EN
    output logic [31:0]                  last_addr_o,
    output logic                         branch_o,
    output logic [31:0]                  branch_target_o
`else
    output logic [31:0]                  last_addr_o
`endif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             LW       = $clog2(DEPTH + 1);
    localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);
    localparam logic [2:0]     LAT_INIT = 3'(RESP_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [2:0]      lat_q;
    logic [2:0]      lat_d;
    logic            grant;

    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [31:0]     fetch_word;

    logic [31:0]     resp_word_p0;
    logic [31:0]     rdata_p1;
    logic            vld_p1;
    logic [31:0]     fetch_cnt_q;
    logic [31:0]     nop_cnt_q;
    logic [31:0]     last_addr_q;

    // -----------------------------------------------------------------------
    // FIFO
    // -----------------------------------------------------------------------
    assign push_ready_o = (level_q != FULL_LVL);
    assign fifo_empty   = (level_q == '0);
    assign push         = push_valid_i && push_ready_o;
    // A word pushed into an empty FIFO is not visible to a grant in the same
    // cycle; that grant receives NOP_INSTR.
    assign pop          = grant && !fifo_empty;
    assign fetch_word   = fifo_empty ? NOP_INSTR : mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_instr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Fetch handshake FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                // Masking with rst_i keeps gnt low while reset is applied.
                grant = instr_req_i && !rst_i;
                if (grant) begin
                    lat_d   = LAT_INIT;
                    state_d = (RESP_LATENCY > 1) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q <= 3'd1) begin
                    state_d = ST_RESP;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            lat_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage p0: word captured at grant, waits here during the latency
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (grant) begin
            resp_word_p0 <= fetch_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            fetch_cnt_q <= '0;
            nop_cnt_q   <= '0;
            last_addr_q <= '0;
        end else if (grant) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
            last_addr_q <= instr_addr_i;
            if (fifo_empty) begin
                nop_cnt_q <= nop_cnt_q + 32'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1: response presented to the core
    // -----------------------------------------------------------------------
    // The output word only changes on entry to RESP so that it holds while
    // rvalid is low. With a one-cycle latency the word comes straight from
    // the FIFO head; otherwise it was parked in resp_word_p0.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_p1 <= NOP_INSTR;
        end else if (state_d == ST_RESP) begin
            rdata_p1 <= grant ? fetch_word : resp_word_p0;
        end
    end

    assign vld_p1 = (state_q == ST_RESP);

`ifdef FETCH_RESP_BRANCH_DETECT_EN
    logic        seen_fetch_q;
    logic        branch_q;
    logic [31:0] branch_target_q;

    // The first grant after reset has no predecessor, so it never counts as
    // a branch.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            seen_fetch_q    <= 1'b0;
            branch_q        <= 1'b0;
            branch_target_q <= '0;
        end else begin
            branch_q <= 1'b0;
            if (grant) begin
                seen_fetch_q <= 1'b1;
                if (seen_fetch_q && (instr_addr_i != last_addr_q + 32'd4)) begin
                    branch_q        <= 1'b1;
                    branch_target_q <= instr_addr_i;
                end
            end
        end
    end

    assign branch_o        = branch_q;
    assign branch_target_o = branch_target_q;
`endif

    assign instr_gnt_o    = grant;
    assign instr_rvalid_o = vld_p1;
    assign instr_rdata_o  = rdata_p1;
    assign level_o        = level_q;
    assign fetch_cnt_o    = fetch_cnt_q;
    assign nop_cnt_o      = nop_cnt_q;
    assign last_addr_o    = last_addr_q;

endmodule

// File: tb/tb_instr_fetch_responder.sv
// ---------------------------------------------------------------------------
// Testbench for instr_fetch_responder. Two instances share one stimulus
// stream: index 0 uses a one-cycle response latency, index 1 uses three.
// A queue-based reference model per instance predicts every output on every
// cycle; directed sequences add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_instr_fetch_responder;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          DEP = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pv;
    logic [31:0] pw;
    logic        req;
    logic [31:0] addr;

    logic [1:0]  ready_w;
    logic [1:0]  gnt_w;
    logic [1:0]  rvalid_w;
    logic [31:0] rdata_w [2];
    logic [4:0]  level_w [2];
    logic [31:0] fetch_w [2];
    logic [31:0] nop_w   [2];
    logic [31:0] last_w  [2];
`ifdef FETCH_RESP_BRANCH_DETECT_EN
    logic [1:0]  br_w;
    logic [31:0] tgt_w   [2];
`endif

    instr_fetch_responder #(.DEPTH(DEP), .RESP_LATENCY(1), .NOP_INSTR(NOP)) u_l1 (
        .clk            (clk),
        .rst_i          (rst),
        .push_valid_i   (pv),
        .push_ready_o   (ready_w[0]),
        .push_instr_i   (pw),
        .instr_req_i    (req),
        .instr_addr_i   (addr),
        .instr_gnt_o    (gnt_w[0]),
        .instr_rvalid_o (rvalid_w[0]),
        .instr_rdata_o  (rdata_w[0]),
        .level_o        (level_w[0]),
        .fetch_cnt_o    (fetch_w[0]),
        .nop_cnt_o      (nop_w[0]),
`ifdef FETCH_RESP_BRANCH_DETECT_EN
        .last_addr_o    (last_w[0]),
        .branch_o       (br_w[0]),
        .branch_target_o(tgt_w[0])
`else
        .last_addr_o    (last_w[0])
`endif
    );

    instr_fetch_responder #(.DEPTH(DEP), .RESP_LATENCY(3), .NOP_INSTR(NOP)) u_l3 (
        .clk            (clk),
        .rst_i          (rst),
        .push_valid_i   (pv),
        .push_ready_o   (ready_w[1]),
        .push_instr_i   (pw),
        .instr_req_i    (req),
        .instr_addr_i   (addr),
        .instr_gnt_o    (gnt_w[1]),
        .instr_rvalid_o (rvalid_w[1]),
        .instr_rdata_o  (rdata_w[1]),
        .level_o        (level_w[1]),
        .fetch_cnt_o    (fetch_w[1]),
        .nop_cnt_o      (nop_w[1]),
`ifdef FETCH_RESP_BRANCH_DETECT_EN
        .last_addr_o    (last_w[1]),
        .branch_o       (br_w[1]),
        .branch_target_o(tgt_w[1])
`else
        .last_addr_o    (last_w[1])
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -----------------------------------------------------------------------
    // Reference model: a word queue plus "cycles until the answer appears"
    // -----------------------------------------------------------------------
    logic [31:0] mq [2][$];
    int          pend    [2];   // -1: nothing outstanding, 0: answering now
    logic [31:0] pdata   [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_fetch [2];
    logic [31:0] m_nop   [2];
    logic [31:0] m_last  [2];
    logic [31:0] m_tgt   [2];
    bit          m_seen  [2];
    bit          m_br    [2];
    bit          mvalid = 1'b0;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    initial begin : compare
        bit          rdy;
        bit          g;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (mvalid) begin
                    chk($sformatf("gnt[%0d]", k), 32'(gnt_w[k]),
                        32'(req && !rst && pend[k] <= 0));
                    chk($sformatf("ready[%0d]", k), 32'(ready_w[k]), 32'(mq[k].size() != DEP));
                    chk($sformatf("level[%0d]", k), 32'(level_w[k]), 32'(mq[k].size()));
                    chk($sformatf("rvalid[%0d]", k), 32'(rvalid_w[k]), 32'(pend[k] == 0));
                    chk($sformatf("rdata[%0d]", k), rdata_w[k], m_rdata[k]);
                    chk($sformatf("fetch_cnt[%0d]", k), fetch_w[k], m_fetch[k]);
                    chk($sformatf("nop_cnt[%0d]", k), nop_w[k], m_nop[k]);
                    chk($sformatf("last_addr[%0d]", k), last_w[k], m_last[k]);
`ifdef FETCH_RESP_BRANCH_DETECT_EN
                    chk($sformatf("branch[%0d]", k), 32'(br_w[k]), 32'(m_br[k]));
                    chk($sformatf("branch_target[%0d]", k), tgt_w[k], m_tgt[k]);
`endif
                end
                // Advance the model by the coming clock edge.
                if (rst) begin
                    mq[k].delete();
                    pend[k]    = -1;
                    pdata[k]   = NOP;
                    m_rdata[k] = NOP;
                    m_fetch[k] = 0;
                    m_nop[k]   = 0;
                    m_last[k]  = 0;
                    m_tgt[k]   = 0;
                    m_seen[k]  = 1'b0;
                    m_br[k]    = 1'b0;
                end else begin
                    rdy = (mq[k].size() != DEP);
                    g   = req && (pend[k] <= 0);
                    m_br[k] = 1'b0;
                    if (pend[k] >= 0) pend[k]--;
                    if (g) begin
                        if (m_seen[k] && addr != m_last[k] + 32'd4) begin
                            m_br[k]  = 1'b1;
                            m_tgt[k] = addr;
                        end
                        if (mq[k].size() > 0) begin
                            w = mq[k].pop_front();
                        end else begin
                            w = NOP;
                            m_nop[k]++;
                        end
                        m_fetch[k]++;
                        m_last[k] = addr;
                        m_seen[k] = 1'b1;
                        pend[k]   = lat_of(k) - 1;
                        pdata[k]  = w;
                    end
                    if (pv && rdy) mq[k].push_back(pw);
                    if (pend[k] == 0) m_rdata[k] = pdata[k];
                end
            end
            if (rst) mvalid = 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus with directed literal expectations, then a random phase
    // -----------------------------------------------------------------------
    initial begin : stim
        logic [31:0] pc;
        int          bias;
        rst  = 1'b1;
        pv   = 1'b0;
        pw   = 32'h0;
        req  = 1'b0;
        addr = 32'h0;
        repeat (3) step();

        // Reset state; grant stays low while reset is applied.
        req = 1'b1;
        chk("rst_level", 32'(level_w[0]), 32'd0);
        chk("rst_rvalid", 32'(rvalid_w[0]), 32'd0);
        chk("rst_rdata", rdata_w[0], 32'h00000013);
        chk("rst_fetch", fetch_w[0], 32'd0);
        chk("rst_last", last_w[0], 32'd0);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt_w[0]), 32'd0);
        step();
        req = 1'b0;

        // Two pushes, then req held: two words and a NOP.
        rst = 1'b0;
        pv  = 1'b1;
        pw  = 32'h00500093;
        step();
        pw  = 32'h00A00113;
        step();
        pv   = 1'b0;
        req  = 1'b1;
        addr = 32'h0;
        @(negedge clk);
        chk("s1_gnt_a", 32'(gnt_w[0]), 32'd1);
        chk("s1_gnt_l3_a", 32'(gnt_w[1]), 32'd1);
        step();
        addr = 32'h4;
        chk("s1_rvalid_1", 32'(rvalid_w[0]), 32'd1);
        chk("s1_rdata_1", rdata_w[0], 32'h00500093);
        chk("s1_l3_rvalid_n1", 32'(rvalid_w[1]), 32'd0);
        @(negedge clk);
        chk("s1_gnt_b", 32'(gnt_w[0]), 32'd1);
        chk("s1_l3_gnt_n1", 32'(gnt_w[1]), 32'd0);
        step();
        addr = 32'h8;
        chk("s1_rdata_2", rdata_w[0], 32'h00A00113);
        chk("s1_l3_rvalid_n2", 32'(rvalid_w[1]), 32'd0);
        @(negedge clk);
        chk("s1_l3_gnt_n2", 32'(gnt_w[1]), 32'd0);
        step();
        req = 1'b0;
        chk("s1_rvalid_3", 32'(rvalid_w[0]), 32'd1);
        chk("s1_rdata_3", rdata_w[0], 32'h00000013);
        chk("s1_fetch_cnt", fetch_w[0], 32'd3);
        chk("s1_nop_cnt", nop_w[0], 32'd1);
        chk("s1_l3_rvalid_n3", 32'(rvalid_w[1]), 32'd1);
        chk("s1_l3_rdata_n3", rdata_w[1], 32'h00500093);
        step();
        chk("s1_hold_rvalid", 32'(rvalid_w[0]), 32'd0);
        chk("s1_hold_rdata", rdata_w[0], 32'h00000013);
        repeat (2) step();

        // Fill to DEPTH, then one grant frees one slot.
        rst = 1'b1;
        step();
        rst = 1'b0;
        pv  = 1'b1;
        for (int i = 0; i < DEP; i++) begin
            pw = 32'h00001000 + 32'(i);
            step();
        end
        pv = 1'b0;
        chk("s2_ready_full", 32'(ready_w[0]), 32'd0);
        chk("s2_level_full", 32'(level_w[0]), 32'd16);
        req = 1'b1;
        step();
        req = 1'b0;
        chk("s2_ready_after", 32'(ready_w[0]), 32'd1);
        chk("s2_level_after", 32'(level_w[0]), 32'd15);
        chk("s2_rdata", rdata_w[0], 32'h00001000);
        repeat (4) step();

        // Push and grant together into an empty FIFO.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        pv   = 1'b1;
        pw   = 32'hCAFE0137;
        req  = 1'b1;
        addr = 32'h100;
        step();
        pv   = 1'b0;
        addr = 32'h104;
        chk("s4_rdata_nop", rdata_w[0], 32'h00000013);
        chk("s4_level", 32'(level_w[0]), 32'd1);
        step();
        req = 1'b0;
        chk("s4_rdata_word", rdata_w[0], 32'hCAFE0137);
        chk("s4_nop_cnt", nop_w[0], 32'd1);
        repeat (4) step();

        // Reset while the latency-3 instance is waiting.
        rst = 1'b1;
        step();
        rst = 1'b0;
        pv  = 1'b1;
        pw  = 32'h00100073;
        step();
        pv  = 1'b0;
        req = 1'b1;
        step();
        req = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_level", 32'(level_w[1]), 32'd0);
        chk("s5_fetch", fetch_w[1], 32'd0);
        chk("s5_nop", nop_w[1], 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s5_rvalid_%0d", i), 32'(rvalid_w[1]), 32'd0);
            step();
        end

`ifdef FETCH_RESP_BRANCH_DETECT_EN
        // Sequential fetch then a jump to 0x40.
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req  = 1'b1;
        addr = 32'h0;
        step();
        addr = 32'h4;
        chk("br_first", 32'(br_w[0]), 32'd0);
        step();
        addr = 32'h40;
        chk("br_seq", 32'(br_w[0]), 32'd0);
        step();
        req = 1'b0;
        chk("br_pulse", 32'(br_w[0]), 32'd1);
        chk("br_target", tgt_w[0], 32'h40);
        step();
        chk("br_pulse_end", 32'(br_w[0]), 32'd0);
        chk("br_target_hold", tgt_w[0], 32'h40);
        repeat (3) step();
`endif

        // Random traffic with shifting push/request balance.
        pc = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bias = (cyc / 250) % 3;
            rst  = ($urandom_range(0, 399) == 0);
            pv   = ($urandom_range(0, 99) < ((bias == 0) ? 25 : (bias == 1) ? 50 : 90));
            pw   = $urandom;
            req  = ($urandom_range(0, 99) < ((bias == 2) ? 30 : (bias == 1) ? 60 : 90));
            if ($urandom_range(0, 7) == 0) pc = $urandom & 32'hFFFFFFFC;
            addr = pc;
            step();
            if (req) pc = pc + 32'd4;
        end
        rst = 1'b0;
        pv  = 1'b0;
        req = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Synthesizable instruction-memory responder, directly upstream of the RISCY core's instruction fetch port (instr_req/gnt/rvalid/addr/rdata).
- The sequence driver pushes instruction words into an internal FIFO. The block answers each core fetch with the next queued word, or a NOP when the queue is empty.
- Replaces hand-toggled instr_rdata driving with a protocol-correct grant/rvalid handshake and configurable response latency.

Parameters:
- DEPTH, 16: FIFO entries (power of 2, ≥2).
- RESP_LATENCY, 1: cycles from grant to rvalid (1..7).
- NOP_INSTR, 32'h00000013: word returned when the FIFO is empty (addi x0,x0,0).

Ports:
- clk  in  1: core clock.
- rst_i  in  1: synchronous reset, active-high.
- push_valid_i  in  1: driver offers an instruction word.
- push_ready_o  out  1: FIFO can accept a word (not full).
- push_instr_i  in  32: instruction word.
- instr_req_i  in  1: core fetch request.
- instr_addr_i  in  32: core fetch address.
- instr_gnt_o  out  1: fetch granted (combinational).
- instr_rvalid_o  out  1: response data valid.
- instr_rdata_o  out  32: response instruction.
- level_o  out  $clog2(DEPTH+1): FIFO occupancy.
- fetch_cnt_o  out  32: number of granted fetches.
- nop_cnt_o  out  32: number of NOP substitutions.
- last_addr_o  out  32: address of the most recent granted fetch.

Behaviour:
- Interface decision: one clock, clk. Reset rst_i is synchronous and active-high.
- Reset values: FIFO empty, level_o=0, gnt=0, rvalid=0, rdata=NOP_INSTR, all counters 0, last_addr_o=0, state IDLE.
- Push side:
  - Word is written when push_valid_i && push_ready_o.
  - push_ready_o = (level_o != DEPTH).
  - When full, push_ready_o is low even if a pop occurs in the same cycle (no pass-through).
- States:
  - IDLE: gnt_o = instr_req_i. On grant:
    - Latch addr into last_addr_o.
    - Pop the FIFO head into the response register, or load NOP_INSTR and increment nop_cnt_o if empty.
    - Increment fetch_cnt_o.
    - Load latency counter with RESP_LATENCY-1.
    - Next state is WAIT if RESP_LATENCY>1, else RESP.
  - WAIT: gnt_o=0. Decrement the counter; go to RESP when it reaches 1.
  - RESP: rvalid_o=1 for exactly this cycle, rdata_o = response register. gnt_o = instr_req_i.
    - A grant here is handled exactly as in IDLE (back-to-back).
    - Otherwise return to IDLE.
- Timing:
  - rvalid is asserted exactly RESP_LATENCY cycles after the grant cycle.
  - At most one fetch is outstanding.
  - With RESP_LATENCY=1, throughput is one fetch per cycle.
- Simultaneous push and pop in one cycle: both take effect. level_o is unchanged.
- Push into an empty FIFO in the same cycle as a grant: the grant receives NOP_INSTR (no bypass). The pushed word serves the next fetch.
- rdata_o holds its last value while rvalid_o=0.
- Pointers wrap modulo DEPTH. Counters wrap at 2^32.
- Reset mid-operation: any pending response is dropped, rvalid_o=0 from the cycle after reset, and FIFO contents are discarded.

Optional Feature:
- Macro: FETCH_RESP_BRANCH_DETECT_EN.
- When defined, adds outputs branch_o (1) and branch_target_o (32).
  - On any grant after the first since reset where instr_addr_i != last_addr_o+4, branch_o pulses for one cycle after the grant.
  - branch_target_o registers that address and holds it until the next detection.
- When undefined, the ports are absent and no comparator logic is built.

Test Plan:
- Reset, push 32'h00500093 and 32'h00A00113, core req held high, RESP_LATENCY=1 → grants on consecutive cycles; rvalid with 00500093 then 00A00113; third fetch returns 00000013; nop_cnt_o=1, fetch_cnt_o=3.
- Push 16 words with DEPTH=16 → push_ready_o=0 and level_o=16. One grant → push_ready_o=1 the next cycle, level_o=15.
- RESP_LATENCY=3, single req at cycle N → gnt at N, rvalid at N+3, gnt low at N+1..N+2 despite req high.
- Push and grant in the same cycle with the FIFO empty → response is 00000013; the next fetch returns the pushed word.
- Assert rst_i in the WAIT state → no rvalid afterwards; level_o=0 and counters=0 on the next cycle.
- With FETCH_RESP_BRANCH_DETECT_EN: fetch 0x00, 0x04, then 0x40 → branch_o pulses once, branch_target_o=0x40.
